key_event_queue: RTL and testbench

- Sits directly downstream of the 5-button debouncer.
- Consumes its press tick (neg_tick), release tick (pos_tick) and registered 3-bit key code.
- Classifies each keystroke as SHORT or LONG press, generates auto-repeat events while a key stays held, and emits a RELEASE event after a long hold.
- Queues the 5-bit events in a small show-ahead FIFO that the logger control logic pops at its own pace.

---
 rtl/key_event_queue.sv | 173 +++++++++++++++++
 tb/tb_key_event_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns debounced key press/release ticks into SHORT / LONG / REPEAT /
//   RELEASE events and queues them in a small show-ahead FIFO.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   neg_tick        one-cycle debounced press pulse
//   pos_tick        one-cycle debounced release pulse
//   kcode[2:0]      key code, valid from the cycle after neg_tick (0 = invalid)
//   rd_en           pop head entry (ignored when empty)
//   clr_ovf         clear sticky overflow flag
//   ev_data[4:0]    head entry {type[1:0], key[2:0]}; holds last value when empty
//   ev_empty        FIFO empty
//   ev_full         FIFO full
//   ev_count[AW:0]  entries held
//   overflow        sticky: an event was dropped
module key_event_queue #(
  parameter int TICK_DIV  = 22118,
  parameter int LONG_MS   = 800,
  parameter int REPEAT_MS = 200,
  parameter int AW        = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          neg_tick,
  input  logic          pos_tick,
  input  logic [2:0]    kcode,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [4:0]    ev_data,
  output logic          ev_empty,
  output logic          ev_full,
  output logic [AW:0]   ev_count,
  output logic          overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    HELD    = 3'd2,
    REPEAT  = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  key_reg;
  logic [PW-1:0] presc;
  logic [15:0] ms_cnt;
  logic        ms_tick;
  logic        tmr_clr;
  logic        push;
  logic [1:0]  push_type;
  logic [4:0]  push_data;
  logic        long_hit, rpt_hit;

  assign ms_tick  = (presc == PW'(TICK_DIV - 1));
  assign long_hit = (ms_cnt == 16'(LONG_MS));
  assign rpt_hit  = (ms_cnt == 16'(REPEAT_MS));
  assign push_data = {push_type, key_reg};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; release has priority over a timer match
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (neg_tick) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (kcode == '0) ? IGNORE : HELD;
      HELD: begin
        if (pos_tick)      state_nxt = IDLE;
        else if (long_hit) state_nxt = REPEAT;
      end
      REPEAT:  if (pos_tick) state_nxt = IDLE;
      IGNORE:  if (pos_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: event push and time-base clear
  always_comb begin
    push      = 1'b0;
    push_type = 2'b00;
    tmr_clr   = 1'b0;
    case (state)
      CAPTURE: tmr_clr = 1'b1;
      HELD: begin
        if (pos_tick) begin
          push      = 1'b1;
          push_type = 2'b00;
        end else if (long_hit) begin
          push      = 1'b1;
          push_type = 2'b01;
          tmr_clr   = 1'b1;
        end
      end
      REPEAT: begin
        if (pos_tick) begin
          push      = 1'b1;
          push_type = 2'b11;
        end else if (rpt_hit) begin
          push      = 1'b1;
          push_type = 2'b10;
          tmr_clr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Key latch
  always_ff @(posedge clk) begin
    if (reset)                 key_reg <= '0;
    else if (state == CAPTURE) key_reg <= kcode;
  end

  // 1 ms time base and saturating ms counter
  always_ff @(posedge clk) begin
    if (reset || tmr_clr) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (ms_tick) begin
      presc <= '0;
      if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // FIFO
  logic [4:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
  logic        do_pop, do_wr, drop;

  assign count    = wr_ptr - rd_ptr;
  assign ev_count = count;
  assign ev_empty = (count == '0);
  assign ev_full  = (count == FULL_CNT);
  assign do_pop   = rd_en && !ev_empty;
  assign do_wr    = push && (!ev_full || do_pop);
  assign drop     = push && ev_full && !do_pop;
  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, do_pop};
  assign wr_nxt   = wr_ptr + {{AW{1'b0}}, do_wr};

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // ev_data is registered from the post-edge head; when the new head is the
  // slot being written this cycle it is taken straight from push_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_data  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt != rd_nxt)
        ev_data <= (do_wr && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt[AW-1:0]];
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue (TICK_DIV=4, LONG_MS=10, REPEAT_MS=3, AW=2).
// Table-driven keystroke vectors, hand-written multi-cycle sequences and a
// randomized run against an event-schedule + queue reference model.
module tb_key_event_queue;

  localparam int TICK_DIV  = 4;
  localparam int LONG_MS   = 10;
  localparam int REPEAT_MS = 3;
  localparam int AW        = 2;
  localparam int DEPTH     = 4;
  // HELD-cycle index at which LONG fires; spacing between timed events
  // (counters restart from zero the cycle after each clear).
  localparam int HL = LONG_MS * TICK_DIV;
  localparam int RP = REPEAT_MS * TICK_DIV + 1;
  localparam int NR = 4000;

  logic        clk = 1'b0;
  logic        reset, neg_tick, pos_tick, rd_en, clr_ovf;
  logic [2:0]  kcode;
  logic [4:0]  ev_data;
  logic        ev_empty, ev_full, overflow;
  logic [AW:0] ev_count;

  int checks = 0;
  int failures = 0;

  key_event_queue #(
    .TICK_DIV(TICK_DIV), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .neg_tick(neg_tick), .pos_tick(pos_tick),
    .kcode(kcode), .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_data(ev_data),
    .ev_empty(ev_empty), .ev_full(ev_full), .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 30)
        $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    neg_tick = 0; pos_tick = 0; rd_en = 0; clr_ovf = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    kcode = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // neg_tick at cycle 0, CAPTURE cycle 1, k HELD cycles, pos_tick after them,
  // then one idle cycle.
  task automatic press(input int code, input int k, input bit rd_at_pos);
    neg_tick = 1; kcode = 3'(code);
    tick();
    neg_tick = 0;
    tick();
    for (int i = 0; i < k; i++) tick();
    pos_tick = 1; rd_en = rd_at_pos;
    tick();
    pos_tick = 0; rd_en = 0;
    tick();
  endtask

  task automatic pop1();
    rd_en = 1; tick(); rd_en = 0;
  endtask

  typedef struct {
    int code; int k; int pops; bit clr;
    int cnt; int head; bit full; bit ovf;
  } vec_t;

  vec_t tbl[10];

  // Random stimulus and event schedule
  bit         neg_a [NR];
  bit         pos_a [NR];
  logic [2:0] kc_a  [NR];
  bit         ev_v  [NR];
  logic [4:0] ev_d  [NR];

  initial begin
    int ecnt;
    int evk[4];
    logic [4:0] q[$];
    logic [4:0] head_last;
    bit mo;

    do_reset();
    chk("reset_count", int'(ev_count), 0);
    chk("reset_empty", int'(ev_empty), 1);
    chk("reset_full", int'(ev_full), 0);
    chk("reset_data", int'(ev_data), 0);
    chk("reset_ovf", int'(overflow), 0);

    // ---------- table-driven keystrokes ----------
    tbl[0] = '{code:2, k:20,  pops:0, clr:0, cnt:1, head:5'h02, full:0, ovf:0};
    tbl[1] = '{code:0, k:100, pops:0, clr:0, cnt:1, head:5'h02, full:0, ovf:0};
    tbl[2] = '{code:5, k:5,   pops:0, clr:0, cnt:2, head:5'h02, full:0, ovf:0};
    tbl[3] = '{code:1, k:0,   pops:0, clr:0, cnt:3, head:5'h02, full:0, ovf:0};
    tbl[4] = '{code:7, k:HL,  pops:0, clr:0, cnt:4, head:5'h02, full:1, ovf:0};
    tbl[5] = '{code:3, k:3,   pops:0, clr:0, cnt:4, head:5'h02, full:1, ovf:1};
    tbl[6] = '{code:4, k:2,   pops:0, clr:1, cnt:4, head:5'h02, full:1, ovf:0};
    tbl[7] = '{code:0, k:1,   pops:1, clr:0, cnt:3, head:5'h05, full:0, ovf:0};
    tbl[8] = '{code:0, k:1,   pops:3, clr:0, cnt:0, head:5'h07, full:0, ovf:0};
    tbl[9] = '{code:6, k:50,  pops:0, clr:0, cnt:2, head:5'h0E, full:0, ovf:0};

    for (int r = 0; r < 10; r++) begin
      press(tbl[r].code, tbl[r].k, 1'b0);
      for (int p = 0; p < tbl[r].pops; p++) pop1();
      if (tbl[r].clr) begin clr_ovf = 1; tick(); clr_ovf = 0; end
      tick();
      chk($sformatf("tbl%0d_count", r), int'(ev_count), tbl[r].cnt);
      chk($sformatf("tbl%0d_head", r), int'(ev_data), tbl[r].head);
      chk($sformatf("tbl%0d_full", r), int'(ev_full), int'(tbl[r].full));
      chk($sformatf("tbl%0d_empty", r), int'(ev_empty), int'(tbl[r].cnt == 0));
      chk($sformatf("tbl%0d_ovf", r), int'(overflow), int'(tbl[r].ovf));
    end

    // ---------- long hold: event order and spacing ----------
    do_reset();
    evk[0] = HL; evk[1] = HL + RP; evk[2] = HL + 2 * RP; evk[3] = 70;
    neg_tick = 1; kcode = 3'b101; tick();
    neg_tick = 0; tick();
    for (int k = 0; k <= 70; k++) begin
      pos_tick = (k == 70);
      tick();
      ecnt = 0;
      for (int e = 0; e < 4; e++) if (evk[e] <= k) ecnt++;
      chk($sformatf("long_count_k%0d", k), int'(ev_count), ecnt);
    end
    pos_tick = 0;
    chk("long_ovf", int'(overflow), 0);
    chk("long_pop0", int'(ev_data), 5'h0D); pop1();
    chk("long_pop1", int'(ev_data), 5'h15); pop1();
    chk("long_pop2", int'(ev_data), 5'h15); pop1();
    chk("long_pop3", int'(ev_data), 5'h1D); pop1();
    chk("long_empty", int'(ev_empty), 1);

    // ---------- push and pop in the same cycle while full ----------
    do_reset();
    for (int c = 1; c <= 4; c++) press(c, 2, 1'b0);
    chk("pp_full_before", int'(ev_full), 1);
    chk("pp_head_before", int'(ev_data), 5'h01);
    press(5, 2, 1'b1);
    chk("pp_count", int'(ev_count), DEPTH);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_head", int'(ev_data), 5'h02);
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("pp_drain%0d", c), int'(ev_data), c);
      pop1();
    end
    chk("pp_empty", int'(ev_empty), 1);
    rd_en = 1; tick(); rd_en = 0;
    chk("pp_pop_empty_count", int'(ev_count), 0);
    chk("pp_pop_empty_data", int'(ev_data), 5'h05);

    // ---------- reset mid-hold ----------
    do_reset();
    press(1, 2, 1'b0);
    press(2, 2, 1'b0);
    neg_tick = 1; kcode = 3'b110; tick();
    neg_tick = 0; tick();
    for (int i = 0; i < HL + 5; i++) tick();
    chk("rst_pre_count", int'(ev_count), 3);
    reset = 1; tick(); reset = 0;
    pos_tick = 1; tick(); pos_tick = 0;
    tick(); tick();
    chk("rst_empty", int'(ev_empty), 1);
    chk("rst_count", int'(ev_count), 0);
    chk("rst_data", int'(ev_data), 0);
    chk("rst_ovf", int'(overflow), 0);

    // ---------- randomized run against schedule + queue model ----------
    for (int c = 0; c < NR; c++) begin
      neg_a[c] = 0; pos_a[c] = 0; ev_v[c] = 0; ev_d[c] = '0;
      kc_a[c] = 3'($urandom_range(0, 7));
    end
    begin
      int t, g, t0, tp, k, code, cat, lc;
      t = 0;
      forever begin
        g = $urandom_range(1, 6);
        t0 = t + g;
        cat = $urandom_range(0, 2);
        k = (cat == 0) ? $urandom_range(0, 45)
          : (cat == 1) ? $urandom_range(HL - 5, HL + 5)
          : $urandom_range(HL + 6, 90);
        tp = t0 + 2 + k;
        if (tp >= NR - 5) break;
        // stray releases while idle are ignored
        for (int i = t; i < t0; i++) pos_a[i] = ($urandom_range(0, 3) == 0);
        code = $urandom_range(0, 7);
        neg_a[t0] = 1;
        for (int c = t0; c <= tp; c++) kc_a[c] = 3'(code);
        // stray presses while a key is held are ignored
        for (int c = t0 + 1; c < tp; c++) neg_a[c] = ($urandom_range(0, 15) == 0);
        pos_a[tp] = 1;
        if (code != 0) begin
          if (k <= HL) begin
            ev_v[tp] = 1; ev_d[tp] = {2'b00, 3'(code)};
          end else begin
            lc = t0 + 2 + HL;
            ev_v[lc] = 1; ev_d[lc] = {2'b01, 3'(code)};
            for (int c = lc + RP; c < tp; c += RP) begin
              ev_v[c] = 1; ev_d[c] = {2'b10, 3'(code)};
            end
            ev_v[tp] = 1; ev_d[tp] = {2'b11, 3'(code)};
          end
        end
        t = tp + 1;
      end
    end

    do_reset();
    q = {};
    head_last = '0;
    mo = 0;
    for (int c = 0; c < NR; c++) begin
      bit rd, clr, pop, fb;
      rd  = (c < NR / 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 19) == 0);
      neg_tick = neg_a[c]; pos_tick = pos_a[c]; kcode = kc_a[c];
      rd_en = rd; clr_ovf = clr;
      tick();
      fb  = (q.size() == DEPTH);
      pop = rd && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (ev_v[c] && fb && !pop) mo = 1;
      else begin
        if (ev_v[c]) q.push_back(ev_d[c]);
        if (clr) mo = 0;
      end
      if (q.size() > 0) head_last = q[0];
      chk($sformatf("rnd%0d_count", c), int'(ev_count), q.size());
      chk($sformatf("rnd%0d_data", c), int'(ev_data), int'(head_last));
      chk($sformatf("rnd%0d_ovf", c), int'(overflow), int'(mo));
      chk($sformatf("rnd%0d_full", c), int'(ev_full), int'(q.size() == DEPTH));
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
